// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared FSM encoding and width helper for the io port bridge
package io_bridge_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/io_port_bridge_if.sv
// io_port_bridge_if: rx/tx streams plus the CPU port signals seen by the bridge
interface io_port_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] In_port;
  logic       cpu_int;
  logic [7:0] Out_port;
  logic       HLT;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport slave (
    input  rx_data, rx_valid, Out_port, HLT, tx_ready,
    output rx_ready, In_port, cpu_int, tx_data, tx_valid
  );
  modport master (
    output rx_data, rx_valid, Out_port, HLT, tx_ready,
    input  rx_ready, In_port, cpu_int, tx_data, tx_valid
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular FIFO; push on full succeeds only with a same-cycle pop
module sync_fifo
  import io_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        din,
  input  logic                    pop,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/io_port_bridge.sv
// io_port_bridge: feeds queued bytes to the CPU In_port with an int pulse, and queues Out_port changes for transmit
module io_port_bridge
  import io_bridge_pkg::*;
#(
  parameter int RX_DEPTH    = 4,
  parameter int TX_DEPTH    = 4,
  parameter int INT_PULSE   = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  io_port_bridge_if.slave           bus,
  output logic [clog2(RX_DEPTH):0]  rx_count,
  output logic                      overrun
);
  localparam int CW = clog2(HOLD_CYCLES > INT_PULSE ? HOLD_CYCLES : INT_PULSE) + 1;
  logic [1:0]               state;
  logic [CW-1:0]            cnt;
  logic [7:0]               in_port;
  logic                     cpu_int;
  logic                     rx_avail;
  logic                     rx_full;
  logic                     rx_empty;
  logic [7:0]               rx_head;
  logic                     load;
  logic [7:0]               out_q;
  logic                     change;
  logic                     tx_full;
  logic                     tx_empty;
  logic                     tx_pop;
  logic [clog2(TX_DEPTH):0] tx_cnt;
  logic                     unused_tx;
  assign unused_tx    = ^tx_cnt;
  assign bus.rx_ready = !rx_full;
  assign bus.In_port  = in_port;
  assign bus.cpu_int  = cpu_int;
  assign bus.tx_valid = !tx_empty;
  assign change       = bus.Out_port != out_q;
  assign tx_pop       = bus.tx_ready && !tx_empty;
  // rx_avail lags occupancy by a cycle, so a fresh byte waits one extra edge before loading
  assign load         = state == IDLE && rx_avail && !rx_empty && !bus.HLT;
  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.rx_valid && !rx_full),
    .din   (bus.rx_data),
    .pop   (load),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .push  (change),
    .din   (bus.Out_port),
    .pop   (tx_pop),
    .dout  (bus.tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      in_port  <= '0;
      cpu_int  <= 1'b0;
      rx_avail <= 1'b0;
    end else begin
      rx_avail <= !rx_empty;
      if (load) begin
        in_port <= rx_head;
        cpu_int <= 1'b1;
        cnt     <= CW'(INT_PULSE - 1);
        state   <= PULSE;
      end else if (state == PULSE) begin
        cpu_int <= cnt != '0;
        cnt     <= cnt == '0 ? CW'(HOLD_CYCLES - 1) : cnt - CW'(1);
        state   <= cnt == '0 ? HOLD : PULSE;
      end else if (state == HOLD) begin
        cnt   <= cnt == '0 ? cnt : cnt - CW'(1);
        state <= cnt == '0 ? IDLE : HOLD;
      end
    end
  end
  // a change arriving on a full TX FIFO is lost unless the sink drains one the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= '0;
      overrun <= 1'b0;
    end else begin
      out_q   <= bus.Out_port;
      overrun <= overrun || (change && tx_full && !tx_pop);
    end
  end
endmodule

// File: tb/tb_io_port_bridge.sv
// tb_io_port_bridge: directed checks of delivery timing, HLT gating, TX capture/overrun and reset
module tb_io_port_bridge;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] rx_count;
  logic       overrun;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         t;
  int         prev_t;
  logic [7:0] rxb [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] txb [5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
  io_port_bridge_if bus();
  io_port_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rx_count (rx_count),
    .overrun  (overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic acc;
    acc = bus.rx_valid && bus.rx_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) bus.rx_valid = 1'b0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wait_load(output int tl);
    logic prev;
    tl = -1;
    for (int i = 0; i < 60; i++) begin
      prev = bus.cpu_int;
      tick();
      if (bus.cpu_int && !prev) begin
        tl = cyc;
        break;
      end
    end
    chk("load_seen", 32'(tl >= 0), 32'd1);
  endtask
  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.Out_port = 8'h00;
    bus.HLT      = 1'b0;
    bus.tx_ready = 1'b0;
    ticks(2);
    chk("rst_in_port", 32'(bus.In_port), 32'h0);
    chk("rst_int", 32'(bus.cpu_int), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_rx_count", 32'(rx_count), 32'h0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    rst = 1'b1;
    tick();
    chk("rx_ready_after_rst", 32'(bus.rx_ready), 32'h1);
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    tick();
    chk("a5_pushed_count", 32'(rx_count), 32'h1);
    chk("a5_int_edge1", 32'(bus.cpu_int), 32'h0);
    tick();
    chk("a5_int_edge1b", 32'(bus.cpu_int), 32'h0);
    chk("a5_in_port_early", 32'(bus.In_port), 32'h0);
    tick();
    chk("a5_in_port", 32'(bus.In_port), 32'hA5);
    chk("a5_int_on", 32'(bus.cpu_int), 32'h1);
    chk("a5_popped", 32'(rx_count), 32'h0);
    prev_t = cyc;
    tick();
    chk("a5_int_cycle2", 32'(bus.cpu_int), 32'h1);
    tick();
    chk("a5_int_off", 32'(bus.cpu_int), 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.rx_data  = rxb[i];
      bus.rx_valid = 1'b1;
      tick();
    end
    chk("rx_full_count", 32'(rx_count), 32'h4);
    chk("rx_ready_full", 32'(bus.rx_ready), 32'h0);
    bus.rx_data  = rxb[4];
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_load(t);
      chk("burst_byte", 32'(bus.In_port), 32'(rxb[i]));
      chk("burst_spacing", 32'(t - prev_t), 32'd19);
      prev_t = t;
    end
    ticks(19);
    bus.HLT      = 1'b1;
    bus.rx_data  = 8'h66;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_data  = 8'h77;
    bus.rx_valid = 1'b1;
    tick();
    ticks(10);
    chk("hlt_no_int", 32'(bus.cpu_int), 32'h0);
    chk("hlt_count", 32'(rx_count), 32'h2);
    chk("hlt_in_port", 32'(bus.In_port), 32'h55);
    bus.HLT = 1'b0;
    tick();
    chk("resume_in_port", 32'(bus.In_port), 32'h66);
    chk("resume_int", 32'(bus.cpu_int), 32'h1);
    chk("resume_count", 32'(rx_count), 32'h1);
    prev_t = cyc;
    wait_load(t);
    chk("resume_byte2", 32'(bus.In_port), 32'h77);
    chk("resume_spacing", 32'(t - prev_t), 32'd19);
    ticks(19);
    bus.tx_ready = 1'b1;
    bus.Out_port = 8'h10;
    tick();
    chk("tx10_valid", 32'(bus.tx_valid), 32'h1);
    chk("tx10_data", 32'(bus.tx_data), 32'h10);
    tick();
    chk("tx_repeat_no_push", 32'(bus.tx_valid), 32'h0);
    bus.Out_port = 8'h20;
    tick();
    chk("tx20_valid", 32'(bus.tx_valid), 32'h1);
    chk("tx20_data", 32'(bus.tx_data), 32'h20);
    tick();
    chk("tx20_drained", 32'(bus.tx_valid), 32'h0);
    chk("tx_no_overrun", 32'(overrun), 32'h0);
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.Out_port = txb[i];
      tick();
    end
    chk("tx_full_valid", 32'(bus.tx_valid), 32'h1);
    chk("tx_full_no_overrun", 32'(overrun), 32'h0);
    bus.Out_port = txb[4];
    tick();
    chk("tx_overrun", 32'(overrun), 32'h1);
    chk("tx_head_stable", 32'(bus.tx_data), 32'h31);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tx_drain_valid", 32'(bus.tx_valid), 32'h1);
      chk("tx_drain_data", 32'(bus.tx_data), 32'(txb[i]));
      tick();
    end
    chk("tx_drained", 32'(bus.tx_valid), 32'h0);
    chk("overrun_sticky", 32'(overrun), 32'h1);
    bus.tx_ready = 1'b0;
    bus.Out_port = 8'h40;
    bus.rx_data  = 8'h99;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_data  = 8'hAA;
    bus.rx_valid = 1'b1;
    tick();
    tick();
    chk("pre_rst_int", 32'(bus.cpu_int), 32'h1);
    chk("pre_rst_in_port", 32'(bus.In_port), 32'h99);
    chk("pre_rst_count", 32'(rx_count), 32'h1);
    chk("pre_rst_tx_valid", 32'(bus.tx_valid), 32'h1);
    bus.Out_port = 8'h00;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_int", 32'(bus.cpu_int), 32'h0);
    chk("async_rst_in_port", 32'(bus.In_port), 32'h0);
    chk("async_rst_overrun", 32'(overrun), 32'h0);
    chk("async_rst_count", 32'(rx_count), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_count", 32'(rx_count), 32'h0);
    chk("post_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("post_rst_rx_ready", 32'(bus.rx_ready), 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- External-side peripheral at the far end of the processor's port interface.
- Drives the CPU's `In_port` and `int` inputs, and consumes the CPU's `Out_port` and `HLT` outputs.
- Inbound bytes arrive on a valid/ready stream, are buffered, presented on `In_port` one at a time, and announced with an interrupt pulse.
- Each CPU `OUT` write, detected as a change of `Out_port`, is queued and emitted on a valid/ready transmit stream.

Parameters:
- RX_DEPTH, 4: inbound FIFO depth in entries; must be a power of two, at least 2.
- TX_DEPTH, 4: outbound FIFO depth in entries; must be a power of two, at least 2.
- INT_PULSE, 2: number of cycles `int` is held high per delivered byte; at least 1.
- HOLD_CYCLES, 16: minimum number of cycles a byte stays alone on `In_port` after its pulse ends, before the next byte may be loaded; at least 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low. The name follows the codebase; the polarity and synchronicity are fixed.
- rx_data  in  8  inbound byte from the external source.
- rx_valid  in  1  `rx_data` is valid.
- rx_ready  out  1  bridge accepts `rx_data` this cycle.
- In_port  out  8  byte presented to the CPU; registered.
- int  out  1  interrupt request to the CPU; registered.
- Out_port  in  8  CPU output port value.
- HLT  in  1  CPU halted flag.
- tx_data  out  8  outbound byte (head of the TX FIFO).
- tx_valid  out  1  `tx_data` is valid.
- tx_ready  in  1  sink accepts `tx_data`.
- rx_count  out  log2(RX_DEPTH)+1  current RX FIFO occupancy.
- overrun  out  1  sticky flag: an `Out_port` change was dropped because the TX FIFO was full.

Behaviour:
- Reset (`rst`=0), asynchronous:
  - `In_port`=0, `int`=0, `overrun`=0, `rx_count`=0, `tx_valid`=0.
  - Both FIFOs are emptied, the FSM goes to IDLE, and the `Out_port` sample register is set to 0.
  - `rx_ready` is 1 from the first edge after release.
  - Assertion mid-operation discards all queued data and drops `int` immediately.
- RX push: on a rising edge where `rx_valid`&`rx_ready`.
  - `rx_ready` = !rx_full (combinational from occupancy).
  - A push and a pop in the same cycle are allowed; occupancy is then unchanged.
- FSM states: IDLE, PULSE, HOLD.
  - IDLE, when RX is non-empty and `HLT`=0: on the next edge, load the head into `In_port`, pop it, set `int`=1, counter = INT_PULSE-1, go to PULSE.
  - PULSE: `int` stays 1. When the counter is 0, on the next edge set `int`=0, counter = HOLD_CYCLES-1, go to HOLD. Otherwise decrement.
  - HOLD: when the counter is 0, go to IDLE on the next edge; otherwise decrement.
  - `In_port` keeps its last value until the next load; it is never cleared except by reset.
- Latency:
  - A byte pushed into an empty FIFO while the FSM is in IDLE appears on `In_port`, with `int`=1, on the second rising edge after the push edge.
  - Back-to-back bytes are spaced exactly 1+INT_PULSE+HOLD_CYCLES cycles apart.
- HLT handling:
  - `HLT`=1 blocks the transition out of IDLE.
  - PULSE and HOLD in progress complete normally.
  - RX pushes and all TX activity continue.
- TX capture: each cycle, `Out_port` is registered into `out_q`.
  - If `Out_port` != `out_q`, push `Out_port` into the TX FIFO.
  - If the TX FIFO is full and no pop occurs that cycle, the byte is dropped and `overrun` is set. `overrun` clears only on reset.
  - A push with a simultaneous pop on a full FIFO succeeds.
  - Known limitation: two successive identical `OUT` values produce a single entry.
- TX pop: on `tx_valid`&`tx_ready`. `tx_valid` = !tx_empty; `tx_data` = head, stable while `tx_valid`=1 and `tx_ready`=0.
- FIFO pointers are log2(DEPTH) bits, wrap modulo DEPTH; occupancy is log2(DEPTH)+1 bits.

Decomposition:
- Shared package `io_bridge_pkg`:
  - FSM state encoding: IDLE=2'd0, PULSE=2'd1, HOLD=2'd2.
  - Counter width function `clog2` for the counter, FIFO pointer and occupancy widths.
- Submodule `sync_fifo` (parameters WIDTH, DEPTH):
  - Instantiated twice, once for RX and once for TX.
  - Ports: push/pop/data, full/empty/count.
  - Asynchronous active-low reset.

Test Plan:
- Reset release, then push 0xA5 with the FSM idle → `In_port`=0xA5 and `int`=1 two edges after the push; `int` high for exactly 2 cycles; next load no earlier than 19 cycles after the first.
- Push 0x11, 0x22, 0x33, 0x44, 0x55 with `rx_valid` held high → `rx_ready` drops when occupancy reaches 4; all five bytes appear on `In_port` in order, spaced 19 cycles apart.
- `HLT`=1 with 2 bytes queued → no `int` pulse and `rx_count` stays 2. Deassert `HLT` → delivery resumes within 1 cycle.
- `Out_port` sequence 0→0x10→0x10→0x20 with `tx_ready`=1 → `tx_valid` pulses twice, delivering 0x10 then 0x20.
- `tx_ready`=0 with 5 distinct `Out_port` changes → 4 entries queued, `overrun`=1, fifth byte dropped; then `tx_ready`=1 drains them in order.
- `rst` asserted during PULSE → `int`=0 and `In_port`=0 immediately; after release, `rx_count`=0 and `tx_valid`=0.
